// File: rtl/tx_serializer_10b.sv
// 10-bit symbol serializer: a 2-entry input FIFO feeds a MSB-first shift register,
// with a post-reset idle preamble and idle-symbol insertion when the FIFO runs dry.
module tx_serializer_10b #(
  parameter logic [9:0]  IDLE_SYM  = 10'b0011111010,
  parameter int unsigned SYNC_SYMS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serial_out,
  output logic       sym_start,
  output logic       is_data,
  output logic [7:0] underrun_cnt
);

  typedef enum logic {
    SYNC,
    RUN
  } state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_SYMS - 1);

  state_t      state_q, state_d;
  logic [9:0]  shreg;
  logic [3:0]  bit_cnt;
  logic [3:0]  sync_cnt;

  logic [9:0]  mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;

  logic        boundary;
  logic        push;
  logic        pop;
  logic        underrun_inc;

  assign data_ready = (count < 2'd2);
  assign push       = data_valid && data_ready;
  assign serial_out = shreg[9];
  assign sym_start  = (bit_cnt == 4'd0);
  assign boundary   = (bit_cnt == 4'd9);

  // Load decision is made only at symbol boundaries; pop reads the registered FIFO
  // state, so a word pushed on this same edge cannot be popped (no bypass).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    underrun_inc = 1'b0;
    if (boundary) begin
      case (state_q)
        SYNC: begin
          if (sync_cnt == SYNC_LAST) begin
            state_d = RUN;
            pop     = (count != 2'd0);
          end
        end
        RUN: begin
          if (count != 2'd0) pop = 1'b1;
          else               underrun_inc = 1'b1;
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      shreg        <= IDLE_SYM;
      bit_cnt      <= 4'd0;
      sync_cnt     <= 4'd0;
      is_data      <= 1'b0;
      underrun_cnt <= 8'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      state_q <= state_d;

      if (boundary) begin
        bit_cnt <= 4'd0;
        shreg   <= pop ? mem[rd_ptr] : IDLE_SYM;
        is_data <= pop;
        if (state_q == SYNC) sync_cnt <= sync_cnt + 4'd1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {shreg[8:0], 1'b0};
      end

      if (underrun_inc && (underrun_cnt != 8'hFF))
        underrun_cnt <= underrun_cnt + 8'd1;

      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the reset count and pointers make stale
  // contents unreachable, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Directed self-checking bench for tx_serializer_10b using hand-derived cycle
// timelines (cycle 0 = first cycle after reset is released).
module tb_tx_serializer_10b;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       serial_out;
  logic       sym_start;
  logic       is_data;
  logic [7:0] underrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] idle_v;
  logic [9:0] syms [3];

  tx_serializer_10b dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .serial_out   (serial_out),
    .sym_start    (sym_start),
    .is_data      (is_data),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next cycle; inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench inside cycle 0.
  task automatic do_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_v  = 10'b0011111010;
    syms[0] = 10'b1001110100;
    syms[1] = 10'b0110001011;
    syms[2] = 10'b1010101010;

    // Reset state and 60+ cycles of pure idle.
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("rst_serial", 32'(serial_out), 32'd0);
        check("rst_sym_start", 32'(sym_start), 32'd1);
        check("rst_ready", 32'(data_ready), 32'd1);
        check("rst_is_data", 32'(is_data), 32'd0);
        check("rst_underrun", 32'(underrun_cnt), 32'd0);
      end
      check("idle_bit", 32'(serial_out), 32'(idle_v[9 - (c % 10)]));
      check("idle_sym_start", 32'(sym_start), 32'((c % 10) == 0));
      if (c <= 40) check("idle_underrun_sync", 32'(underrun_cnt), 32'd0);
      if (c == 50) check("idle_underrun_50", 32'(underrun_cnt), 32'd1);
      if (c == 60) check("idle_underrun_60", 32'(underrun_cnt), 32'd2);
      tick();
    end

    // Single push at cycle 5 is sent at 40..49, then an underrun idle.
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      data_valid = (c == 5);
      data_in    = syms[0];
      @(negedge clk);
      if (c >= 40 && c <= 49) begin
        check("one_bit", 32'(serial_out), 32'(syms[0][9 - (c - 40)]));
        check("one_is_data", 32'(is_data), 32'd1);
      end
      if (c == 50) begin
        check("one_idle_start", 32'(sym_start), 32'd1);
        check("one_idle_is_data", 32'(is_data), 32'd0);
        check("one_idle_bit", 32'(serial_out), 32'(idle_v[9]));
        check("one_underrun", 32'(underrun_cnt), 32'd1);
      end
      tick();
    end

    // Back-pressure: A,B accepted at 0,1; C at 40; sent back-to-back from 40.
    do_reset();
    begin
      int idx;
      idx = 0;
      for (int c = 0; c <= 69; c++) begin
        data_valid = (idx < 3);
        data_in    = syms[idx < 3 ? idx : 2];
        @(negedge clk);
        if (c <= 40) check("bp_ready", 32'(data_ready), 32'((c < 2) || (c == 40)));
        if (c >= 40) begin
          check("bp_bit", 32'(serial_out), 32'(syms[(c - 40) / 10][9 - ((c - 40) % 10)]));
          check("bp_is_data", 32'(is_data), 32'd1);
        end
        if ((c < 2) || (c == 40)) idx++;
        tick();
      end
      data_valid = 1'b0;
    end

    // Push at cycle 39: not visible at the SYNC boundary; data goes out at 50.
    do_reset();
    for (int c = 0; c <= 59; c++) begin
      data_valid = (c == 39);
      data_in    = syms[1];
      @(negedge clk);
      if (c >= 40 && c <= 49) begin
        check("late_idle_bit", 32'(serial_out), 32'(idle_v[9 - (c - 40)]));
        check("late_idle_is_data", 32'(is_data), 32'd0);
      end
      if (c == 50) check("late_underrun", 32'(underrun_cnt), 32'd0);
      if (c >= 50) begin
        check("late_bit", 32'(serial_out), 32'(syms[1][9 - (c - 50)]));
        check("late_is_data", 32'(is_data), 32'd1);
      end
      tick();
    end

    // Reset at cycle 45 mid data symbol with one word queued; queue is dropped.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      data_valid = (c == 5) || (c == 6);
      data_in    = (c == 5) ? syms[0] : syms[2];
      rst        = (c == 45);
      @(negedge clk);
      if (c == 44) check("mid_is_data", 32'(is_data), 32'd1);
      tick();
    end
    rst        = 1'b0;
    data_valid = 1'b0;
    for (int c = 46; c <= 95; c++) begin
      @(negedge clk);
      if (c == 46) begin
        check("mid_rst_serial", 32'(serial_out), 32'd0);
        check("mid_rst_sym_start", 32'(sym_start), 32'd1);
        check("mid_rst_underrun", 32'(underrun_cnt), 32'd0);
        check("mid_rst_ready", 32'(data_ready), 32'd1);
      end
      check("mid_idle_bit", 32'(serial_out), 32'(idle_v[9 - ((c - 46) % 10)]));
      check("mid_idle_is_data", 32'(is_data), 32'd0);
      tick();
    end
    @(negedge clk);
    check("mid_underrun_after", 32'(underrun_cnt), 32'd1);

    // Saturation: underrun_cnt = k at cycle 40+10k until it sticks at 255.
    do_reset();
    for (int c = 0; c <= 3100; c++) begin
      @(negedge clk);
      if (c == 2580) check("sat_254", 32'(underrun_cnt), 32'd254);
      if (c == 2590) check("sat_255", 32'(underrun_cnt), 32'd255);
      if (c == 3100) check("sat_hold", 32'(underrun_cnt), 32'd255);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
